// File: rtl/pipe_ctrl.sv
// Pipeline control: resolves per-stage stall requests, multi-cycle EX ops and exception flushes.
// Latency: stall/flush/new_pc combinational (0 cycles); mc_busy/mc_timeout/mc_abort registered (1 cycle).
// Backpressure: a held stage freezes itself and every upstream stage; the next stage downstream gets a bubble.
//
// Ports:
//    clk, rst        single clock, synchronous active-high reset (all outputs forced 0 while rst=1)
//    stallreq        per-stage hold request, bit k from stage k (bit 0 = PC)
//    mc_start        one-cycle pulse: EX begins a multi-cycle op
//    mc_done         multi-cycle result valid this cycle
//    except_valid    exception/eret committing this cycle
//    except_target   handler/return PC
//    stall           freeze vector, bit 0 = PC, bit k = stage register k
//    flush           kill all in-flight stage contents
//    new_pc          redirect PC, valid when flush=1 (0 otherwise)
//    mc_busy         a multi-cycle op is outstanding
//    mc_timeout      one-cycle pulse: the multi-cycle watchdog expired
//    mc_abort        one-cycle pulse: the multi-cycle wait was abandoned by an exception
//    stall_cycles    count of cycles with the PC frozen
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating stall_cycles counter;
// without it stall_cycles is tied to 0 and no counter register exists.
//
// Parameter legal ranges: EX_IDX in 1..STAGES-2, MC_MAX_CYCLES >= 2.

module pipe_ctrl #(
   parameter int STAGES        = 6,
   parameter int EX_IDX        = 3,
   parameter int MC_MAX_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STAGES-1:0] stallreq,
   input  logic              mc_start,
   input  logic              mc_done,
   input  logic              except_valid,
   input  logic [31:0]       except_target,
   output logic [STAGES-1:0] stall,
   output logic              flush,
   output logic [31:0]       new_pc,
   output logic              mc_busy,
   output logic              mc_timeout,
   output logic              mc_abort,
   output logic [31:0]       stall_cycles
);

   localparam int CNT_W = $clog2(MC_MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_MAX_CYCLES - 1);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MC_WAIT = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
   logic              abort_q, abort_d;

   logic              mc_hold;
   logic [STAGES-1:0] req_vec;
   logic [STAGES-1:0] stall_mask;
   logic              fill_acc;

   // ------------------------------------------------------------------
   // Effective request vector
   // ------------------------------------------------------------------
   // The EX hold is raised in the start cycle itself (the op has not been
   // accepted yet) and for every wait cycle except the one delivering the
   // result, so the result is captured on that edge.
   always_comb begin
      mc_hold = 1'b0;
      if (state_q == ST_IDLE)
         mc_hold = mc_start;
      else
         mc_hold = !mc_done;
   end

   always_comb begin
      req_vec         = stallreq;
      req_vec[EX_IDX] = stallreq[EX_IDX] | mc_hold;
   end

   // ------------------------------------------------------------------
   // Stall mask: every bit at or below the highest requesting stage.
   // Scanning from the top keeps a running OR, so bit i is set whenever any
   // stage >= i asks to hold; the stage just above the highest request is
   // left running and therefore receives a bubble.
   // ------------------------------------------------------------------
   always_comb begin
      fill_acc   = 1'b0;
      stall_mask = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         fill_acc      = fill_acc | req_vec[i];
         stall_mask[i] = fill_acc;
      end
   end

   // ------------------------------------------------------------------
   // Multi-cycle FSM and watchdog
   // ------------------------------------------------------------------
   // In MC_WAIT a result arriving in the same cycle as an exception still
   // counts as a normal completion: the flush kills the instruction, but the
   // unit did finish, so no abort is reported.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      abort_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mc_start && !except_valid) begin
               state_d = ST_MC_WAIT;
               cnt_d   = '0;
            end
         end
         ST_MC_WAIT: begin
            // a fresh mc_start here is deliberately ignored
            if (mc_done) begin
               state_d = ST_IDLE;
            end else if (except_valid) begin
               state_d = ST_IDLE;
               abort_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         abort_q   <= abort_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // An exception redirect wins over every hold: the pipeline is being
   // emptied, so freezing any stage would only preserve dead state.
   always_comb begin
      stall  = '0;
      flush  = 1'b0;
      new_pc = '0;
      if (!rst) begin
         if (except_valid) begin
            flush  = 1'b1;
            new_pc = except_target;
         end else begin
            stall = stall_mask;
         end
      end
   end

   assign mc_busy    = !rst && (state_q == ST_MC_WAIT);
   assign mc_timeout = !rst && timeout_q;
   assign mc_abort   = !rst && abort_q;

   // ------------------------------------------------------------------
   // Stall-cycle performance counter
   // ------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q;

   // stall is already forced to 0 under reset, so stall[0] alone qualifies
   // a countable cycle; saturate instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= '0;
      else if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cycles = rst ? 32'd0 : stall_cnt_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed multi-cycle sequences, random run vs model.
// Latency: one DUT clock per applied vector; outputs sampled on the falling edge.
// Backpressure: n/a (bench drives every input directly).

module tb_pipe_ctrl;

   localparam int MAXC = 8;

   logic        clk;
   logic        rst;
   logic [5:0]  stallreq;
   logic        mc_start;
   logic        mc_done;
   logic        except_valid;
   logic [31:0] except_target;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        mc_busy;
   logic        mc_timeout;
   logic        mc_abort;
   logic [31:0] stall_cycles;

   pipe_ctrl #(.STAGES(6), .EX_IDX(3), .MC_MAX_CYCLES(MAXC)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq     (stallreq),
      .mc_start     (mc_start),
      .mc_done      (mc_done),
      .except_valid (except_valid),
      .except_target(except_target),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .mc_busy      (mc_busy),
      .mc_timeout   (mc_timeout),
      .mc_abort     (mc_abort),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit          m_busy;
   bit          m_to;
   bit          m_ab;
   int          m_start_cyc;
   int          cyc;
   logic [31:0] m_cnt;

   // outputs sampled in the most recent cycle
   logic [5:0]  s_stall;
   logic        s_flush;
   logic [31:0] s_pc;
   logic        s_busy;
   logic        s_to;
   logic        s_ab;
   logic [31:0] s_cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Stall from the rules: find the highest requesting stage, freeze it and everything below.
   function automatic logic [5:0] model_stall();
      logic [5:0] r;
      int         k;
      bit         hold;
      if (rst || except_valid) return 6'd0;
      hold = m_busy ? !mc_done : mc_start;
      r = stallreq;
      if (hold) r = r | 6'b001000;
      k = -1;
      for (int i = 0; i < 6; i++) if (r[i]) k = i;
      if (k < 0) return 6'd0;
      return 6'((1 << (k + 1)) - 1);
   endfunction

   // One clock: sample and compare on the falling edge, advance the model across the rising edge.
   task automatic run_cycle(input string tag);
      logic [5:0]  e_stall;
      logic [31:0] e_cyc;
      bit          n_busy, n_to, n_ab;
      @(negedge clk);
      s_stall = stall;  s_flush = flush;  s_pc = new_pc;
      s_busy = mc_busy; s_to = mc_timeout; s_ab = mc_abort; s_cyc = stall_cycles;
      e_stall = model_stall();
`ifdef PIPE_CTRL_PERF_EN
      e_cyc = rst ? 32'd0 : m_cnt;
`else
      e_cyc = 32'd0;
`endif
      chk({tag, ".stall"},   {26'd0, s_stall}, {26'd0, e_stall});
      chk({tag, ".flush"},   {31'd0, s_flush}, {31'd0, (!rst && except_valid)});
      chk({tag, ".new_pc"},  s_pc, (!rst && except_valid) ? except_target : 32'd0);
      chk({tag, ".busy"},    {31'd0, s_busy},  {31'd0, (!rst && m_busy)});
      chk({tag, ".timeout"}, {31'd0, s_to},    {31'd0, (!rst && m_to)});
      chk({tag, ".abort"},   {31'd0, s_ab},    {31'd0, (!rst && m_ab)});
      chk({tag, ".perf"},    s_cyc, e_cyc);

      n_busy = m_busy; n_to = 0; n_ab = 0;
      if (rst) begin
         n_busy = 0;
         m_cnt  = 0;
      end else begin
         if (m_busy) begin
            if (mc_done)                         n_busy = 0;
            else if (except_valid)               begin n_busy = 0; n_ab = 1; end
            else if (cyc - m_start_cyc == MAXC)  begin n_busy = 0; n_to = 1; end
         end else if (mc_start && !except_valid) begin
            n_busy      = 1;
            m_start_cyc = cyc;
         end
         if (e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      @(posedge clk);
      m_busy = n_busy; m_to = n_to; m_ab = n_ab;
      cyc++;
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; stallreq = 0; mc_start = 0; mc_done = 0; except_valid = 0; except_target = 0;
   endtask

   typedef struct {
      logic [5:0]  req;
      logic        ex;
      logic [31:0] tgt;
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vt[9];

   initial begin
      vt[0] = '{6'b000100, 1'b0, 32'h0,         6'b000111, 1'b0, 32'h0};
      vt[1] = '{6'b001100, 1'b0, 32'h0,         6'b001111, 1'b0, 32'h0};
      vt[2] = '{6'b000000, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0};
      vt[3] = '{6'b100000, 1'b0, 32'h0,         6'b111111, 1'b0, 32'h0};
      vt[4] = '{6'b000001, 1'b0, 32'h0,         6'b000001, 1'b0, 32'h0};
      vt[5] = '{6'b010010, 1'b0, 32'h0,         6'b011111, 1'b0, 32'h0};
      vt[6] = '{6'b111111, 1'b1, 32'h8000_0180, 6'b000000, 1'b1, 32'h8000_0180};
      vt[7] = '{6'b000000, 1'b0, 32'hBFC0_0380, 6'b000000, 1'b0, 32'h0};
      vt[8] = '{6'b000000, 1'b1, 32'h0000_1234, 6'b000000, 1'b1, 32'h0000_1234};

      idle_inputs();
      rst = 1;
      m_busy = 0; m_to = 0; m_ab = 0; m_start_cyc = 0; cyc = 0; m_cnt = 0;
      @(posedge clk); #1;

      // reset state, with inputs active to show they are ignored
      stallreq = 6'b111111; mc_start = 1; except_valid = 1; except_target = 32'hFFFF_0000;
      run_cycle("reset");
      chk("reset.all_zero", {s_stall, s_flush, s_busy, s_to, s_ab}, 32'd0);
      idle_inputs(); rst = 1;
      run_cycle("reset2");
      idle_inputs();
      run_cycle("post_reset");

      // combinational vector table, IDLE state
      for (int i = 0; i < 9; i++) begin
         idle_inputs();
         stallreq = vt[i].req; except_valid = vt[i].ex; except_target = vt[i].tgt;
         run_cycle($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.tbl_stall", i), {26'd0, s_stall}, {26'd0, vt[i].e_stall});
         chk($sformatf("vec%0d.tbl_flush", i), {31'd0, s_flush}, {31'd0, vt[i].e_flush});
         chk($sformatf("vec%0d.tbl_pc", i), s_pc, vt[i].e_pc);
      end
      idle_inputs();
      run_cycle("gap0");

      // multi-cycle op completing after 5 cycles
      mc_start = 1;
      run_cycle("mc5.t0");
      chk("mc5.t0_stall", {26'd0, s_stall}, 32'h0F);
      chk("mc5.t0_busy", {31'd0, s_busy}, 32'd0);
      mc_start = 0;
      for (int i = 1; i <= 4; i++) begin
         run_cycle("mc5.wait");
         chk("mc5.wait_stall", {26'd0, s_stall}, 32'h0F);
         chk("mc5.wait_busy", {31'd0, s_busy}, 32'd1);
      end
      mc_done = 1;
      run_cycle("mc5.done");
      chk("mc5.done_stall", {26'd0, s_stall}, 32'd0);
      chk("mc5.done_busy", {31'd0, s_busy}, 32'd1);
      mc_done = 0;
      run_cycle("mc5.after");
      chk("mc5.after_busy", {31'd0, s_busy}, 32'd0);
      chk("mc5.after_pulses", {30'd0, s_to, s_ab}, 32'd0);

      // watchdog; mc_start held during the wait must not restart it
      mc_start = 1;
      run_cycle("to.t0");
      for (int i = 1; i <= MAXC; i++) begin
         run_cycle("to.wait");
         chk("to.wait_stall", {26'd0, s_stall}, 32'h0F);
         chk("to.wait_pulse", {31'd0, s_to}, 32'd0);
      end
      mc_start = 0;
      run_cycle("to.fire");
      chk("to.fire_pulse", {31'd0, s_to}, 32'd1);
      chk("to.fire_busy", {31'd0, s_busy}, 32'd0);
      chk("to.fire_stall", {26'd0, s_stall}, 32'd0);
      run_cycle("to.after");
      chk("to.after_pulse", {31'd0, s_to}, 32'd0);

      // exception during the wait
      mc_start = 1;
      run_cycle("ab.t0");
      mc_start = 0;
      run_cycle("ab.w1");
      run_cycle("ab.w2");
      except_valid = 1; except_target = 32'hBFC0_0380; stallreq = 6'b000100;
      run_cycle("ab.ex");
      chk("ab.ex_flush", {31'd0, s_flush}, 32'd1);
      chk("ab.ex_pc", s_pc, 32'hBFC0_0380);
      chk("ab.ex_stall", {26'd0, s_stall}, 32'd0);
      chk("ab.ex_abort", {31'd0, s_ab}, 32'd0);
      idle_inputs();
      run_cycle("ab.pulse");
      chk("ab.pulse_abort", {31'd0, s_ab}, 32'd1);
      chk("ab.pulse_busy", {31'd0, s_busy}, 32'd0);
      run_cycle("ab.after");
      chk("ab.after_abort", {31'd0, s_ab}, 32'd0);

      // exception and result in the same wait cycle: completion, not abort
      mc_start = 1;
      run_cycle("de.t0");
      mc_start = 0;
      run_cycle("de.w1");
      mc_done = 1; except_valid = 1; except_target = 32'h0040_0000;
      run_cycle("de.both");
      chk("de.both_flush", {31'd0, s_flush}, 32'd1);
      idle_inputs();
      run_cycle("de.after");
      chk("de.after_abort", {31'd0, s_ab}, 32'd0);
      chk("de.after_busy", {31'd0, s_busy}, 32'd0);

      // reset mid-wait with stall requests pending
      mc_start = 1;
      run_cycle("rw.t0");
      mc_start = 0;
      run_cycle("rw.w1");
      rst = 1; stallreq = 6'b100110;
      run_cycle("rw.rst");
      run_cycle("rw.rst2");
      chk("rw.rst_outputs", {s_stall, s_flush, s_busy, s_to, s_ab}, 32'd0);
      idle_inputs(); mc_done = 1;
      run_cycle("rw.done_alone");
      chk("rw.done_stall", {26'd0, s_stall}, 32'd0);
      chk("rw.done_busy", {31'd0, s_busy}, 32'd0);
      mc_done = 0;
      run_cycle("rw.after");
      chk("rw.after_pulses", {30'd0, s_to, s_ab}, 32'd0);

`ifdef PIPE_CTRL_PERF_EN
      // ten stalled cycles from a clean reset, then saturation from a preload
      rst = 1;
      run_cycle("pf.rst");
      idle_inputs(); stallreq = 6'b000001;
      for (int i = 0; i < 10; i++) run_cycle("pf.stall");
      stallreq = 0;
      run_cycle("pf.read");
      chk("pf.ten", s_cyc, 32'd10);
      dut.stall_cnt_q = 32'hFFFF_FFFD;
      m_cnt = 32'hFFFF_FFFD;
      stallreq = 6'b000001;
      for (int i = 0; i < 4; i++) run_cycle("pf.sat");
      stallreq = 0;
      run_cycle("pf.sat_read");
      chk("pf.saturated", s_cyc, 32'hFFFF_FFFF);
`endif

      // randomized run against the model
      for (int n = 0; n < 1500; n++) begin
         rst           = ($urandom_range(63) == 0);
         stallreq      = $urandom_range(1) ? 6'd0 : 6'($urandom);
         mc_start      = ($urandom_range(5) == 0);
         mc_done       = ($urandom_range(7) == 0);
         except_valid  = ($urandom_range(15) == 0);
         except_target = $urandom;
         run_cycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the mycpu pipeline. It drives the `StallBus` vector that freezes PC and the stage registers, and it is the single point that resolves per-stage stall requests, multi-cycle execute operations with a watchdog, and exception flushes. It sits beside IF/ID/EX/MEM/WB in `mycpu_core`, in place of the fixed-output control block.

## Interface
Parameters:
- `STAGES`, 6: width of `stall`; bit 0 = PC, bit k = stage register k (1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB).
- `EX_IDX`, 3: stall bit index raised by multi-cycle ops; legal range 1..STAGES-2.
- `MC_MAX_CYCLES`, 64: watchdog limit for one multi-cycle op; ≥2.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stallreq`  in  STAGES  per-stage hold request; bit k from stage k (e.g. ID load-use on bit 2).
- `mc_start`  in  1  EX starts a multi-cycle op (div/mul); one-cycle pulse.
- `mc_done`  in  1  multi-cycle result valid this cycle.
- `except_valid`  in  1  exception/eret committing this cycle.
- `except_target`  in  32  handler/return PC.
- `stall`  out  STAGES  freeze vector.
- `flush`  out  1  kill all in-flight stage contents.
- `new_pc`  out  32  redirect PC, valid when `flush`=1.
- `mc_busy`  out  1  FSM in MC_WAIT.
- `mc_timeout`  out  1  one-cycle pulse: watchdog expired.
- `mc_abort`  out  1  one-cycle pulse: MC_WAIT left due to exception.
- `stall_cycles`  out  32  perf counter (see Configuration).

## Operation
- Effective request vector R = `stallreq`, with bit `EX_IDX` ORed with (`mc_start` in IDLE) or (MC_WAIT and !`mc_done`).
- k = highest set bit of R; `stall` = mask with bits 0..k set, upper bits 0. Stage k+1 receives a bubble (stall[k]=1, stall[k+1]=0). R=0 → `stall`=0.
- `except_valid` has priority: `flush`=1, `new_pc`=`except_target`, `stall`=0 in that cycle regardless of R. `new_pc`=0 when `flush`=0.
- FSM states:
  - IDLE: `mc_start` & !`except_valid` → MC_WAIT, counter cleared.
  - MC_WAIT: `mc_done` → IDLE; else `except_valid` → IDLE with `mc_abort`; else counter = MC_MAX_CYCLES-1 → IDLE with `mc_timeout`; else counter+1.
- Priority in MC_WAIT: `except_valid` over `mc_done` only for `flush`; `mc_done` still returns to IDLE without `mc_abort`.
- `mc_start` while in MC_WAIT is ignored.
- Counter width = $clog2(MC_MAX_CYCLES+1).

## Timing
- `stall`, `flush`, `new_pc`: combinational from inputs and registered state; zero latency.
- `mc_start` at cycle t: stall bits 0..EX_IDX high from t until the cycle `mc_done` is seen, in which they drop (result captured at that edge).
- `mc_busy`: registered; high from t+1 through the `mc_done` cycle.
- `mc_timeout` and `mc_abort`: registered; high in the cycle after the triggering condition for exactly 1 cycle.
- Timeout: with no `mc_done`, stall is high for cycles t..t+MC_MAX_CYCLES, and `mc_timeout` is high at t+MC_MAX_CYCLES+1.
- Reset: state IDLE, counter 0, `stall`=0, `flush`=0, `new_pc`=0, `mc_busy`=0, `mc_timeout`=0, `mc_abort`=0, `stall_cycles`=0. While `rst`=1 all outputs are forced 0 and inputs are ignored. Reset mid-MC_WAIT returns to IDLE with no pulse.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_cycles` increments on every non-reset cycle with `stall[0]`=1 and saturates at 32'hFFFF_FFFF; it clears only on reset.
- Undefined: the counter register is not built and `stall_cycles` is tied to 0.

## Test plan
- `stallreq`=6'b000100 → `stall`=6'b000111, `flush`=0; `stallreq`=6'b001100 → `stall`=6'b001111.
- `mc_start` at t, `mc_done` at t+5 → `stall`=6'b001111 for t..t+4, 0 at t+5; `mc_busy` high t+1..t+5.
- `MC_MAX_CYCLES`=8, `mc_start` with no `mc_done` → stall high t..t+8, `mc_timeout` pulse at t+9, `mc_busy` 0 after.
- MC_WAIT plus `except_valid` with `except_target`=32'hBFC0_0380 → same cycle `flush`=1, `new_pc`=32'hBFC0_0380, `stall`=0; `mc_abort` pulse the next cycle.
- `rst` asserted mid-MC_WAIT and with `stallreq`≠0 → all outputs 0 the next cycle; after release, `mc_done` alone → `stall`=0, no pulses.
- `PIPE_CTRL_PERF_EN` defined, 10 stalled cycles → `stall_cycles`=10; counter preloaded near max saturates at 32'hFFFF_FFFF.
